cluster_chunk_loader: RTL and testbench

// - Autonomous sequencer between Mem_IFM/Mem_Filter and Compute_Cluster; replaces externally driven count/sel/chunk inputs.
// - Per command: streams one IFM chunk, optionally one filter chunk per compute unit, into the cluster's idle ping-pong bank.
// - Then swaps banks and starts the cluster run. The next load overlaps the current run (double buffering).

---
 rtl/cluster_chunk_loader_if.sv | 61 ++++++
 rtl/cluster_chunk_loader.sv | 212 +++++++++++++++++++++
 tb/tb_cluster_chunk_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_chunk_loader_if.sv
// ============================================================================
// Module  : cluster_chunk_loader_if
// Purpose : Command, memory-read and cluster-write signals of the chunk loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cluster_chunk_loader_if #(
    parameter int BUS_SIZE      = 32,
    parameter int MEM_SIZE      = 128,
    parameter int CU_NUM        = 4,
    parameter int IFM_CHUNK_NUM = 8,
    parameter int FLT_CHUNK_NUM = 32
);
    localparam int CYC = MEM_SIZE / BUS_SIZE;
    localparam int CW  = $clog2(CYC);
    localparam int IAW = $clog2(IFM_CHUNK_NUM);
    localparam int FAW = $clog2(FLT_CHUNK_NUM);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [IAW-1:0]    cmd_ifm_chunk_i;
    logic [FAW-1:0]    cmd_flt_base_i;
    logic              cmd_load_flt_i;
    logic [IAW-1:0]    mem_ifm_rd_chunk_o;
    logic [CW-1:0]     mem_ifm_rd_dat_o;
    logic [FAW-1:0]    mem_flt_rd_chunk_o;
    logic [CW-1:0]     mem_flt_rd_dat_o;
    logic              ifm_wr_valid_o;
    logic [CW-1:0]     ifm_wr_count_o;
    logic              ifm_wr_sel_o;
    logic              ifm_rd_sel_o;
    logic              flt_wr_valid_o;
    logic [CW-1:0]     flt_wr_count_o;
    logic              flt_wr_sel_o;
    logic              flt_rd_sel_o;
    logic [CU_NUM-1:0] flt_wr_chunk_sel_o;
    logic              run_valid_o;
    logic              chunk_start_o;
    logic              chunk_end_i;

    // Loader side
    modport master (
        input  cmd_valid_i, cmd_ifm_chunk_i, cmd_flt_base_i, cmd_load_flt_i, chunk_end_i,
        output cmd_ready_o, mem_ifm_rd_chunk_o, mem_ifm_rd_dat_o, mem_flt_rd_chunk_o,
               mem_flt_rd_dat_o, ifm_wr_valid_o, ifm_wr_count_o, ifm_wr_sel_o, ifm_rd_sel_o,
               flt_wr_valid_o, flt_wr_count_o, flt_wr_sel_o, flt_rd_sel_o,
               flt_wr_chunk_sel_o, run_valid_o, chunk_start_o
    );

    // Command source / memory / cluster side
    modport slave (
        output cmd_valid_i, cmd_ifm_chunk_i, cmd_flt_base_i, cmd_load_flt_i, chunk_end_i,
        input  cmd_ready_o, mem_ifm_rd_chunk_o, mem_ifm_rd_dat_o, mem_flt_rd_chunk_o,
               mem_flt_rd_dat_o, ifm_wr_valid_o, ifm_wr_count_o, ifm_wr_sel_o, ifm_rd_sel_o,
               flt_wr_valid_o, flt_wr_count_o, flt_wr_sel_o, flt_rd_sel_o,
               flt_wr_chunk_sel_o, run_valid_o, chunk_start_o
    );
endinterface

`default_nettype wire

// File: rtl/cluster_chunk_loader.sv
// ============================================================================
// Module  : cluster_chunk_loader
// Purpose : Streams IFM/filter chunks into the idle ping-pong bank, then swaps
//           banks and starts the cluster; next load overlaps the current run.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cluster_chunk_loader #(
    parameter int BUS_SIZE      = 32,
    parameter int MEM_SIZE      = 128,
    parameter int CU_NUM        = 4,
    parameter int IFM_CHUNK_NUM = 8,
    parameter int FLT_CHUNK_NUM = 32,
    parameter int RD_LAT        = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cluster_chunk_loader_if.master bus
);
    localparam int CYC = MEM_SIZE / BUS_SIZE;
    localparam int CW  = $clog2(CYC);
    localparam int IAW = $clog2(IFM_CHUNK_NUM);
    localparam int FAW = $clog2(FLT_CHUNK_NUM);
    localparam int KW  = (CU_NUM > 1) ? $clog2(CU_NUM) : 1;
    localparam int DW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [CW-1:0] C_LAST_BEAT  = CW'(CYC - 1);
    localparam logic [KW-1:0] C_LAST_CU    = KW'(CU_NUM - 1);
    localparam logic [DW-1:0] C_LAST_DRAIN = DW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_IFM = 3'd1,
        LD_FLT = 3'd2,
        DRAIN  = 3'd3,
        SWAP   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               beat_q, beat_d;
    logic [KW-1:0]               cu_q, cu_d;
    logic [DW-1:0]               drain_q, drain_d;
    logic [IAW-1:0]              ifm_chunk_q, ifm_chunk_d;
    logic [FAW-1:0]              flt_base_q, flt_base_d;
    logic                        load_flt_q, load_flt_d;
    logic                        ifm_sel_q, ifm_sel_d;
    logic                        flt_sel_q, flt_sel_d;
    logic                        busy_q, busy_d;
    logic                        start_q, start_d;
    logic [RD_LAT-1:0]           ifm_v_pipe_q, ifm_v_pipe_d;
    logic [RD_LAT-1:0]           flt_v_pipe_q, flt_v_pipe_d;
    logic [RD_LAT-1:0][CW-1:0]   cnt_pipe_q, cnt_pipe_d;
    logic [RD_LAT-1:0][CU_NUM-1:0] sel_pipe_q, sel_pipe_d;

    logic                        issue_ifm;
    logic                        issue_flt;
    logic [CU_NUM-1:0]           issue_onehot;

    assign issue_ifm    = (state_q == LD_IFM);
    assign issue_flt    = (state_q == LD_FLT);
    assign issue_onehot = issue_flt ? (CU_NUM'(1) << cu_q) : '0;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cu_d        = cu_q;
        drain_d     = drain_q;
        ifm_chunk_d = ifm_chunk_q;
        flt_base_d  = flt_base_q;
        load_flt_d  = load_flt_q;
        ifm_sel_d   = ifm_sel_q;
        flt_sel_d   = flt_sel_q;
        busy_d      = busy_q;
        start_d     = 1'b0;

        if (busy_q && bus.chunk_end_i) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    ifm_chunk_d = bus.cmd_ifm_chunk_i;
                    flt_base_d  = bus.cmd_flt_base_i;
                    load_flt_d  = bus.cmd_load_flt_i;
                    beat_d      = '0;
                    state_d     = LD_IFM;
                end
            end
            LD_IFM: begin
                if (beat_q == C_LAST_BEAT) begin
                    beat_d  = '0;
                    cu_d    = '0;
                    drain_d = '0;
                    state_d = load_flt_q ? LD_FLT : DRAIN;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            LD_FLT: begin
                if (beat_q == C_LAST_BEAT) begin
                    beat_d = '0;
                    if (cu_q == C_LAST_CU) begin
                        cu_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        cu_d = cu_q + KW'(1);
                    end
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == C_LAST_DRAIN) begin
                    drain_d = '0;
                    state_d = SWAP;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            SWAP: begin
                // busy is registered, so an end-of-run pulse frees the swap one cycle later
                if (!busy_q) begin
                    ifm_sel_d = ~ifm_sel_q;
                    if (load_flt_q) begin
                        flt_sel_d = ~flt_sel_q;
                    end
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write side replays the issue side RD_LAT cycles later so data n lands with count n
    always_comb begin
        ifm_v_pipe_d    = ifm_v_pipe_q;
        flt_v_pipe_d    = flt_v_pipe_q;
        cnt_pipe_d      = cnt_pipe_q;
        sel_pipe_d      = sel_pipe_q;
        ifm_v_pipe_d[0] = issue_ifm;
        flt_v_pipe_d[0] = issue_flt;
        cnt_pipe_d[0]   = beat_q;
        sel_pipe_d[0]   = issue_onehot;
        for (int i = 1; i < RD_LAT; i++) begin
            ifm_v_pipe_d[i] = ifm_v_pipe_q[i-1];
            flt_v_pipe_d[i] = flt_v_pipe_q[i-1];
            cnt_pipe_d[i]   = cnt_pipe_q[i-1];
            sel_pipe_d[i]   = sel_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            cu_q         <= '0;
            drain_q      <= '0;
            ifm_chunk_q  <= '0;
            flt_base_q   <= '0;
            load_flt_q   <= 1'b0;
            ifm_sel_q    <= 1'b0;
            flt_sel_q    <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            ifm_v_pipe_q <= '0;
            flt_v_pipe_q <= '0;
            cnt_pipe_q   <= '0;
            sel_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cu_q         <= cu_d;
            drain_q      <= drain_d;
            ifm_chunk_q  <= ifm_chunk_d;
            flt_base_q   <= flt_base_d;
            load_flt_q   <= load_flt_d;
            ifm_sel_q    <= ifm_sel_d;
            flt_sel_q    <= flt_sel_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            ifm_v_pipe_q <= ifm_v_pipe_d;
            flt_v_pipe_q <= flt_v_pipe_d;
            cnt_pipe_q   <= cnt_pipe_d;
            sel_pipe_q   <= sel_pipe_d;
        end
    end

    assign bus.cmd_ready_o        = (state_q == IDLE);
    assign bus.mem_ifm_rd_chunk_o = issue_ifm ? ifm_chunk_q : '0;
    assign bus.mem_ifm_rd_dat_o   = issue_ifm ? beat_q : '0;
    // Filter chunk index wraps modulo FLT_CHUNK_NUM through natural truncation
    assign bus.mem_flt_rd_chunk_o = issue_flt ? (flt_base_q + FAW'(cu_q)) : '0;
    assign bus.mem_flt_rd_dat_o   = issue_flt ? beat_q : '0;
    assign bus.ifm_wr_valid_o     = ifm_v_pipe_q[RD_LAT-1];
    assign bus.ifm_wr_count_o     = cnt_pipe_q[RD_LAT-1];
    assign bus.ifm_wr_sel_o       = ifm_sel_q;
    assign bus.ifm_rd_sel_o       = ~ifm_sel_q;
    assign bus.flt_wr_valid_o     = flt_v_pipe_q[RD_LAT-1];
    assign bus.flt_wr_count_o     = cnt_pipe_q[RD_LAT-1];
    assign bus.flt_wr_sel_o       = flt_sel_q;
    assign bus.flt_rd_sel_o       = ~flt_sel_q;
    assign bus.flt_wr_chunk_sel_o = sel_pipe_q[RD_LAT-1];
    assign bus.run_valid_o        = busy_q;
    assign bus.chunk_start_o      = start_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_chunk_loader.sv
// ============================================================================
// Module  : tb_cluster_chunk_loader
// Purpose : Scoreboard bench for cluster_chunk_loader (RD_LAT=1 and RD_LAT=3).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cluster_chunk_loader;
    localparam int LAT = 1;
    localparam logic [31:0] C_RST_PACK = 32'h1C00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cluster_chunk_loader_if #(.BUS_SIZE(32), .MEM_SIZE(128), .CU_NUM(4),
                              .IFM_CHUNK_NUM(8), .FLT_CHUNK_NUM(32)) bus ();
    cluster_chunk_loader_if #(.BUS_SIZE(32), .MEM_SIZE(128), .CU_NUM(4),
                              .IFM_CHUNK_NUM(8), .FLT_CHUNK_NUM(32)) bus3 ();

    cluster_chunk_loader #(.BUS_SIZE(32), .MEM_SIZE(128), .CU_NUM(4), .IFM_CHUNK_NUM(8),
                           .FLT_CHUNK_NUM(32), .RD_LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    cluster_chunk_loader #(.BUS_SIZE(32), .MEM_SIZE(128), .CU_NUM(4), .IFM_CHUNK_NUM(8),
                           .FLT_CHUNK_NUM(32), .RD_LAT(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus3.master)
    );

    typedef struct packed {logic [2:0] chunk; logic [1:0] cnt;} ifm_exp_t;
    typedef struct packed {logic [4:0] chunk; logic [3:0] sel; logic [1:0] cnt;} flt_exp_t;

    ifm_exp_t   ifm_q[$];
    flt_exp_t   flt_q[$];
    logic [3:0] swap_q[$];
    logic       m_ifm_sel = 1'b0;
    logic       m_flt_sel = 1'b0;
    logic [4:0] ih[0:LAT];
    logic [6:0] fh[0:LAT];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_a();
        return 32'({bus.cmd_ready_o, bus.ifm_rd_sel_o, bus.flt_rd_sel_o, bus.ifm_wr_sel_o,
                    bus.flt_wr_sel_o, bus.ifm_wr_valid_o, bus.flt_wr_valid_o, bus.run_valid_o,
                    bus.chunk_start_o, bus.ifm_wr_count_o, bus.flt_wr_count_o,
                    bus.flt_wr_chunk_sel_o, bus.mem_ifm_rd_chunk_o, bus.mem_ifm_rd_dat_o,
                    bus.mem_flt_rd_chunk_o, bus.mem_flt_rd_dat_o});
    endfunction

    // Called just after a negedge; returns at the negedge of the first load cycle.
    task automatic send_cmd(input logic [2:0] ifm, input logic [4:0] base, input logic ld);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid_i     = 1'b1;
        bus.cmd_ifm_chunk_i = ifm;
        bus.cmd_flt_base_i  = base;
        bus.cmd_load_flt_i  = ld;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.cmd_ready_o) begin
                ok = 1'b1;
                for (int b = 0; b < 4; b++) ifm_q.push_back({ifm, 2'(b)});
                if (ld) begin
                    for (int k = 0; k < 4; k++)
                        for (int b = 0; b < 4; b++)
                            flt_q.push_back({5'((int'(base) + k) % 32), 4'(1 << k), 2'(b)});
                end
                m_ifm_sel = ~m_ifm_sel;
                if (ld) m_flt_sel = ~m_flt_sel;
                swap_q.push_back({m_ifm_sel, m_flt_sel, ~m_ifm_sel, ~m_flt_sel});
            end
            @(negedge clk);
        end
        bus.cmd_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_start(input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (bus.chunk_start_o) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("start_timeout", 32'(seen), 32'd1);
    endtask

    task automatic pulse_end();
        bus.chunk_end_i = 1'b1;
        @(negedge clk);
        bus.chunk_end_i = 1'b0;
    endtask

    // Scoreboard: every write must match the next expected beat and the read issued LAT cycles earlier
    always @(negedge clk) begin
        if (rst_n) begin
            ifm_exp_t ie;
            flt_exp_t fe;
            logic [3:0] se;
            for (int i = LAT; i > 0; i--) begin
                ih[i] = ih[i-1];
                fh[i] = fh[i-1];
            end
            ih[0] = {bus.mem_ifm_rd_chunk_o, bus.mem_ifm_rd_dat_o};
            fh[0] = {bus.mem_flt_rd_chunk_o, bus.mem_flt_rd_dat_o};
            if (bus.ifm_wr_valid_o) begin
                if (ifm_q.size() == 0) chk("ifm_extra_wr", 32'(ifm_q.size()), 32'd1);
                else begin
                    ie = ifm_q.pop_front();
                    chk("ifm_wr_count", 32'(bus.ifm_wr_count_o), 32'(ie.cnt));
                    chk("ifm_rd_beat", 32'(ih[LAT]), 32'({ie.chunk, ie.cnt}));
                end
            end
            if (bus.flt_wr_valid_o) begin
                if (flt_q.size() == 0) chk("flt_extra_wr", 32'(flt_q.size()), 32'd1);
                else begin
                    fe = flt_q.pop_front();
                    chk("flt_wr_count", 32'(bus.flt_wr_count_o), 32'(fe.cnt));
                    chk("flt_chunk_sel", 32'(bus.flt_wr_chunk_sel_o), 32'(fe.sel));
                    chk("flt_rd_beat", 32'(fh[LAT]), 32'({fe.chunk, fe.cnt}));
                end
            end else begin
                chk("flt_sel_idle", 32'(bus.flt_wr_chunk_sel_o), 32'd0);
            end
            if (bus.chunk_start_o) begin
                if (swap_q.size() == 0) chk("extra_start", 32'(swap_q.size()), 32'd1);
                else begin
                    se = swap_q.pop_front();
                    chk("swap_sels", 32'({bus.ifm_wr_sel_o, bus.flt_wr_sel_o,
                                          bus.ifm_rd_sel_o, bus.flt_rd_sel_o}), 32'(se));
                    chk("run_at_start", 32'(bus.run_valid_o), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [10:0] v_wv, v_cs, v_rd, v_rv;
        int          n_ok, n_cs;
        logic        run_all;

        bus.cmd_valid_i = 1'b0;  bus.cmd_ifm_chunk_i = '0;  bus.cmd_flt_base_i = '0;
        bus.cmd_load_flt_i = 1'b0;  bus.chunk_end_i = 1'b0;
        bus3.cmd_valid_i = 1'b0; bus3.cmd_ifm_chunk_i = '0; bus3.cmd_flt_base_i = '0;
        bus3.cmd_load_flt_i = 1'b0; bus3.chunk_end_i = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_outputs", pack_a(), C_RST_PACK);
        rst_n = 1'b1;
        @(negedge clk);

        // IFM-only load into an idle cluster
        send_cmd(3'd3, 5'd0, 1'b0);
        v_wv = '0; v_cs = '0; v_rd = '0;
        for (int t = 1; t <= 8; t++) begin
            if (t > 1) @(negedge clk);
            v_wv[t] = bus.ifm_wr_valid_o;
            v_cs[t] = bus.chunk_start_o;
            v_rd[t] = (bus.mem_ifm_rd_chunk_o == 3'd3) && (bus.mem_ifm_rd_dat_o == 2'(t - 1));
        end
        chk("t1_rd_cycles", 32'(v_rd), 32'h01E);
        chk("t1_wv_cycles", 32'(v_wv), 32'h03C);
        chk("t1_start_cycle", 32'(v_cs), 32'h080);
        chk("t1_ifm_wr_sel", 32'(bus.ifm_wr_sel_o), 32'd1);
        chk("t1_flt_wr_sel", 32'(bus.flt_wr_sel_o), 32'd0);
        pulse_end();
        chk("t1_run_clear", 32'(bus.run_valid_o), 32'd0);

        // Filter load with base wrap-around 30,31,0,1
        send_cmd(3'd5, 5'd30, 1'b1);
        wait_start(60);
        chk("t2_flt_wr_sel", 32'(bus.flt_wr_sel_o), 32'd1);
        @(negedge clk);
        pulse_end();
        chk("t2_run_clear", 32'(bus.run_valid_o), 32'd0);

        // Second load while the cluster is busy must hold in SWAP
        send_cmd(3'd1, 5'd0, 1'b0);
        wait_start(60);
        @(negedge clk);
        send_cmd(3'd6, 5'd7, 1'b1);
        run_all = 1'b1; n_cs = 0;
        repeat (40) begin
            @(negedge clk);
            run_all = run_all & bus.run_valid_o;
            if (bus.chunk_start_o) n_cs++;
        end
        chk("t3_run_held", 32'(run_all), 32'd1);
        chk("t3_no_start", 32'(n_cs), 32'd0);
        chk("t3_not_ready", 32'(bus.cmd_ready_o), 32'd0);
        pulse_end();
        v_rv = '0; v_cs = '0;
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) @(negedge clk);
            v_rv[t] = bus.run_valid_o;
            v_cs[t] = bus.chunk_start_o;
        end
        chk("t3_run_gap", 32'(v_rv), 32'h00C);
        chk("t3_start_2cyc", 32'(v_cs), 32'h004);
        pulse_end();
        chk("t3_run_clear", 32'(bus.run_valid_o), 32'd0);

        // RD_LAT=3 instance: writes trail reads by 3 cycles, 3-cycle drain
        bus3.cmd_valid_i = 1'b1; bus3.cmd_ifm_chunk_i = 3'd2; bus3.cmd_load_flt_i = 1'b0;
        @(negedge clk);
        bus3.cmd_valid_i = 1'b0;
        v_wv = '0; v_cs = '0; v_rd = '0; n_ok = 0;
        for (int t = 1; t <= 10; t++) begin
            if (t > 1) @(negedge clk);
            v_rd[t] = (bus3.mem_ifm_rd_chunk_o == 3'd2) && (bus3.mem_ifm_rd_dat_o == 2'(t - 1));
            v_wv[t] = bus3.ifm_wr_valid_o;
            v_cs[t] = bus3.chunk_start_o;
            if (bus3.ifm_wr_valid_o && bus3.ifm_wr_count_o == 2'(t - 4)) n_ok++;
        end
        chk("t4_rd_cycles", 32'(v_rd), 32'h01E);
        chk("t4_wv_cycles", 32'(v_wv), 32'h0F0);
        chk("t4_wr_counts", 32'(n_ok), 32'd4);
        chk("t4_start_cycle", 32'(v_cs), 32'h200);
        chk("t4_ifm_wr_sel", 32'(bus3.ifm_wr_sel_o), 32'd1);

        // Asynchronous reset in the middle of a filter load
        send_cmd(3'd0, 5'd10, 1'b1);
        repeat (6) @(negedge clk);
        chk("t5_mid_flt", 32'(bus.flt_wr_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_rst", pack_a(), C_RST_PACK);
        ifm_q.delete(); flt_q.delete(); swap_q.delete();
        m_ifm_sel = 1'b0; m_flt_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", 32'(bus.cmd_ready_o), 32'd1);
        send_cmd(3'd7, 5'd0, 1'b0);
        wait_start(60);
        @(negedge clk);
        pulse_end();

        repeat (3) @(negedge clk);
        chk("ifm_q_empty", 32'(ifm_q.size()), 32'd0);
        chk("flt_q_empty", 32'(flt_q.size()), 32'd0);
        chk("swap_q_empty", 32'(swap_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
